spi_frame_receiver: RTL and testbench

//   Host-facing input stage for the cube controller. Receives one frame of RGB pixel

---
 rtl/spi_frame_receiver.sv | 145 ++++++++++++++
 tb/tb_spi_frame_receiver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: synchronizes the host link to clk, assembles 24-bit
// pixels MSB first and issues one frame-memory write per completed pixel.
module spi_frame_receiver #(
   parameter int unsigned NUM_PIXELS  = 4096,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [23:0]       wr_data,
   output logic              frame_done,
   output logic              frame_error,
   output logic              busy
);

   typedef enum logic [1:0] {ARMWAIT, IDLE, RECV, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic [23:0]            shift_q, shift_d;
   logic [4:0]             bitcnt_q, bitcnt_d;
   logic [ADDR_W-1:0]      pixcnt_q, pixcnt_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [23:0]            wr_data_q, wr_data_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic sclk_s, mosi_s, cs_s;
   logic sclk_rise, cs_rise, cs_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   // cs_n synchronizer resets to 0 so ARMWAIT only exits once a real high propagates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ARMWAIT;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         pixcnt_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         pixcnt_q  <= pixcnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      pixcnt_d  = pixcnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = err_q;
      case (state_q)
         ARMWAIT: if (cs_s) state_d = IDLE;
         IDLE: begin
            if (cs_fall) begin
               state_d  = RECV;
               shift_d  = '0;
               bitcnt_d = '0;
               pixcnt_d = '0;
               err_d    = 1'b0;
            end
         end
         RECV: begin
            // cs_n release wins over a pixel that completed in the same or previous cycle.
            if (cs_rise) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (bitcnt_q == 5'd24) begin
               wr_en_d   = 1'b1;
               wr_data_d = shift_q;
               wr_addr_d = pixcnt_q;
               bitcnt_d  = '0;
               if (pixcnt_q == LAST_PIX) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  pixcnt_d = pixcnt_q + 1'b1;
               end
            end else if (sclk_rise) begin
               shift_d  = {shift_q[22:0], mosi_s};
               bitcnt_d = bitcnt_q + 5'd1;
            end
         end
         DONE: begin
            if (sclk_rise) err_d = 1'b1;
            if (cs_rise) state_d = IDLE;
         end
         default: state_d = ARMWAIT;
      endcase
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_done  = done_q;
   assign frame_error = err_q;
   assign busy        = (state_q == RECV);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a 4-pixel frame: table-driven frame
// check plus hand-written abort, overrun, reset, latency and back-to-back sequences.
module tb_spi_frame_receiver;

   localparam int unsigned NPIX = 4;
   localparam int unsigned AW   = 12;
   localparam int unsigned SYNC = 2;

   logic          clk = 1'b0;
   logic          reset_n, spi_sclk, spi_mosi, spi_cs_n;
   logic          wr_en, frame_done, frame_error, busy;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_data;

   spi_frame_receiver #(.NUM_PIXELS(NPIX), .ADDR_W(AW), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [23:0]   pix;
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } vec_t;

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } wr_t;

   int unsigned cyc = 0;
   wr_t         cap_q[$];
   int unsigned done_cnt = 0;
   logic [AW-1:0] done_addr;
   logic        done_with_wr;
   int unsigned last_raw;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) cap_q.push_back('{cyc, wr_addr, wr_data});
      if (frame_done) begin
         done_cnt++;
         done_addr    = wr_addr;
         done_with_wr = wr_en;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_bit(input logic b, input logic mark);
      spi_mosi = b;
      tick(4);
      spi_sclk = 1'b1;
      if (mark) last_raw = cyc;
      tick(4);
      spi_sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [23:0] v, input int unsigned n);
      for (int i = 23; i > 23 - int'(n); i--) send_bit(v[i], (i == 0));
   endtask

   task automatic frame_start();
      spi_cs_n = 1'b0;
      tick(4);
   endtask

   task automatic frame_end();
      tick(8);
      spi_cs_n = 1'b1;
      tick(8);
   endtask

   vec_t        tbl[NPIX];
   logic [23:0] exp_q[$];
   int unsigned raw_q[$];
   int unsigned base, dbase;

   initial begin
      tbl[0] = '{24'h112233, 12'd0, 24'h112233};
      tbl[1] = '{24'h445566, 12'd1, 24'h445566};
      tbl[2] = '{24'h778899, 12'd2, 24'h778899};
      tbl[3] = '{24'hAABBCC, 12'd3, 24'hAABBCC};

      reset_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
      tick(3);
      check("reset_wr_en", 64'(wr_en), 64'd0);
      check("reset_wr_addr", 64'(wr_addr), 64'd0);
      check("reset_wr_data", 64'(wr_data), 64'd0);
      check("reset_flags", 64'({frame_done, frame_error, busy}), 64'd0);
      reset_n = 1'b1;
      tick(6);

      // 1: clean frame from the vector table
      base = cap_q.size(); dbase = done_cnt;
      frame_start();
      send_bits(tbl[0].pix, 12);
      check("busy_in_frame", 64'(busy), 64'd1);
      send_bits(tbl[0].pix << 12, 12);
      for (int i = 1; i < int'(NPIX); i++) send_bits(tbl[i].pix, 24);
      frame_end();
      check("t1_wr_count", 64'(cap_q.size() - base), 64'(NPIX));
      for (int i = 0; i < int'(NPIX); i++) begin
         if (base + i < cap_q.size()) begin
            check("t1_addr", 64'(cap_q[base+i].addr), 64'(tbl[i].addr));
            check("t1_data", 64'(cap_q[base+i].data), 64'(tbl[i].data));
         end
      end
      check("t1_done_count", 64'(done_cnt - dbase), 64'd1);
      check("t1_done_addr", 64'({done_with_wr, done_addr}), 64'({1'b1, 12'd3}));
      check("t1_error", 64'(frame_error), 64'd0);
      check("t1_busy_after", 64'(busy), 64'd0);

      // 2: short frame, then recovery
      base = cap_q.size(); dbase = done_cnt;
      frame_start();
      send_bits(24'h0F0F0F, 24);
      send_bits(24'hF0F0F0, 24);
      send_bits(24'h123456, 10);
      frame_end();
      check("t2_wr_count", 64'(cap_q.size() - base), 64'd2);
      check("t2_error", 64'(frame_error), 64'd1);
      check("t2_no_done", 64'(done_cnt - dbase), 64'd0);
      base = cap_q.size(); dbase = done_cnt;
      frame_start();
      check("t2_err_cleared_at_start", 64'(frame_error), 64'd0);
      for (int i = 0; i < int'(NPIX); i++) send_bits(24'h000100 + 24'(i), 24);
      frame_end();
      check("t2_wr_count2", 64'(cap_q.size() - base), 64'(NPIX));
      if (cap_q.size() > base)
         check("t2_first_addr", 64'(cap_q[base].addr), 64'd0);
      check("t2_done", 64'(done_cnt - dbase), 64'd1);
      check("t2_error2", 64'(frame_error), 64'd0);

      // 3: overrun
      base = cap_q.size(); dbase = done_cnt;
      frame_start();
      for (int i = 0; i < int'(NPIX); i++) send_bits(24'h5A5A00 + 24'(i), 24);
      send_bits(24'hFF0000, 8);
      frame_end();
      check("t3_wr_count", 64'(cap_q.size() - base), 64'(NPIX));
      check("t3_done", 64'(done_cnt - dbase), 64'd1);
      check("t3_error", 64'(frame_error), 64'd1);

      // 4: reset mid-pixel with cs_n held low
      frame_start();
      send_bits(24'hC0FFEE, 24);
      send_bits(24'hABCDEF, 10);
      tick(8);
      reset_n = 1'b0;
      #1;
      check("t4_async_clear", 64'({wr_en, wr_addr, wr_data, frame_done, frame_error, busy}), 64'd0);
      tick(3);
      reset_n = 1'b1;
      base = cap_q.size();
      send_bits(24'hABCDEF, 14);
      send_bits(24'h123456, 24);
      tick(8);
      check("t4_no_writes", 64'(cap_q.size() - base), 64'd0);
      check("t4_not_busy", 64'(busy), 64'd0);
      spi_cs_n = 1'b1;
      tick(8);
      base = cap_q.size();
      frame_start();
      for (int i = 0; i < int'(NPIX); i++) send_bits(24'h330000 + 24'(i), 24);
      frame_end();
      check("t4_wr_count", 64'(cap_q.size() - base), 64'(NPIX));
      if (cap_q.size() > base)
         check("t4_first", 64'({cap_q[base].addr, cap_q[base].data}), 64'({12'd0, 24'h330000}));

      // 5: random data, two frames, scoreboard and latency
      base = cap_q.size();
      for (int f = 0; f < 2; f++) begin
         frame_start();
         for (int i = 0; i < int'(NPIX); i++) begin
            logic [23:0] d;
            d = 24'($urandom);
            exp_q.push_back(d);
            send_bits(d, 24);
            raw_q.push_back(last_raw);
         end
         frame_end();
      end
      check("t5_wr_count", 64'(cap_q.size() - base), 64'(2 * NPIX));
      for (int i = 0; i < int'(2 * NPIX); i++) begin
         if (base + i < cap_q.size()) begin
            check("t5_data", 64'(cap_q[base+i].data), 64'(exp_q[i]));
            check("t5_addr", 64'(cap_q[base+i].addr), 64'(i % int'(NPIX)));
            check("t5_latency", 64'(cap_q[base+i].cyc - raw_q[i]), 64'(SYNC + 2));
         end
      end

      // 6: back-to-back frames, cs_n high for 4 clks
      base = cap_q.size(); dbase = done_cnt;
      frame_start();
      for (int i = 0; i < int'(NPIX); i++) send_bits(24'h010203 * 24'(i + 1), 24);
      tick(8);
      spi_cs_n = 1'b1;
      tick(4);
      spi_cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < int'(NPIX); i++) send_bits(24'h0A0B0C + 24'(i), 24);
      frame_end();
      check("t6_wr_count", 64'(cap_q.size() - base), 64'(2 * NPIX));
      check("t6_done", 64'(done_cnt - dbase), 64'd2);
      if (cap_q.size() >= base + 2 * NPIX)
         check("t6_second_first", 64'({cap_q[base+NPIX].addr, cap_q[base+NPIX].data}),
               64'({12'd0, 24'h0A0B0C}));
      check("t6_error", 64'(frame_error), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
